// File: rtl/imem_fetch_port.sv
// Instruction-memory responder for the PC fetch interface: synchronous read, fixed
// LATENCY pipeline, FWFT output FIFO. Optional counters under `FETCH_STATS_EN`.
module imem_fetch_port #(
  parameter int          DEPTH        = 256,
  parameter int          LATENCY      = 2,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] ILLEGAL_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_addr,
  output logic [31:0] resp_instr,
  output logic        resp_err,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetches,
  output logic [31:0] stat_flushes,
  output logic [31:0] stat_stalls
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } fetch_rsp_t;

  logic [31:0]   mem [DEPTH];
  logic [LATENCY:1] vld_pipe;
  fetch_rsp_t    pipe [LATENCY:1];
  fetch_rsp_t    fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [OW-1:0] fifo_cnt, occ;

  logic       accept, rd_in_range, wr_in_range;
  logic       fifo_empty, last_v, fifo_push, fifo_pop, pop;
  fetch_rsp_t rd_entry, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_in_range = req_addr < 32'(DEPTH);
  assign wr_in_range = wr_addr < 32'(DEPTH);
  assign req_ready   = !flush && (occ < OW'(FIFO_DEPTH));
  assign accept      = req_valid && req_ready;

  always_comb begin
    rd_entry       = '0;
    rd_entry.addr  = req_addr;
    rd_entry.instr = rd_in_range ? mem[req_addr[AW-1:0]] : ILLEGAL_WORD;
    rd_entry.err   = !rd_in_range;
  end

  // The last stage falls through to the output when the FIFO is empty, so the
  // response is visible LATENCY cycles after accept instead of one cycle later.
  assign fifo_empty = (fifo_cnt == '0);
  assign last_v     = vld_pipe[LATENCY];
  assign resp_valid = !fifo_empty || last_v;
  assign pop        = resp_valid && resp_ready;
  assign fifo_pop   = !fifo_empty && resp_ready;
  assign fifo_push  = last_v && !(fifo_empty && resp_ready);

  always_comb begin
    head = fifo_empty ? pipe[LATENCY] : fifo[rd_ptr];
    if (!resp_valid) head = '0;
  end

  assign resp_addr  = head.addr;
  assign resp_instr = head.instr;
  assign resp_err   = head.err;

  // Memory has no reset so program contents survive it.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) mem[wr_addr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (accept) pipe[1] <= rd_entry;
    for (int i = 2; i <= LATENCY; i++) pipe[i] <= pipe[i-1];
    if (fifo_push) fifo[wr_ptr] <= pipe[LATENCY];
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld_pipe <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      occ      <= '0;
    end else begin
      vld_pipe[1] <= accept;
      for (int i = 2; i <= LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (fifo_push) wr_ptr <= ptr_inc(wr_ptr);
      if (fifo_pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + OW'(fifo_push) - OW'(fifo_pop);
      occ      <= occ + OW'(accept) - OW'(pop);
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetches <= '0;
      stat_flushes <= '0;
      stat_stalls  <= '0;
    end else begin
      if (accept && stat_fetches != '1)                 stat_fetches <= stat_fetches + 1'b1;
      if (flush && stat_flushes != '1)                  stat_flushes <= stat_flushes + 1'b1;
      if (req_valid && !req_ready && stat_stalls != '1) stat_stalls  <= stat_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed bench for imem_fetch_port at default parameters (LATENCY=2, FIFO_DEPTH=4, DEPTH=256).
module tb_imem_fetch_port;
  logic        clk = 0;
  logic        reset = 1;
  logic        req_valid = 0;
  logic [31:0] req_addr = 0;
  logic        req_ready;
  logic        flush = 0;
  logic        resp_valid;
  logic        resp_ready = 0;
  logic [31:0] resp_addr, resp_instr;
  logic        resp_err;
  logic        wr_en = 0;
  logic [31:0] wr_addr = 0, wr_data = 0;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetches, stat_flushes, stat_stalls;
`endif

  int nvec = 0, nerr = 0;

  imem_fetch_port dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_addr(resp_addr), .resp_instr(resp_instr), .resp_err(resp_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef FETCH_STATS_EN
    , .stat_fetches(stat_fetches), .stat_flushes(stat_flushes), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int next_addr, acc, rx;

  initial begin
    // Reset and initial state
    tick(); tick();
    #1;
    chk("rst_valid", 32'(resp_valid), 0);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_addr", resp_addr, 0);
    chk("rst_instr", resp_instr, 0);
    chk("rst_err", 32'(resp_err), 0);
    tick(); reset = 0;

    // Program load mem[i] = 0x100 + i
    for (int i = 0; i < 32; i++) begin
      tick(); wr_en = 1; wr_addr = i; wr_data = 32'h100 + i;
    end
    tick(); wr_en = 0;

    // Stream: 8 back-to-back fetches, responses two cycles later
    resp_ready = 1;
    for (int c = 0; c < 12; c++) begin
      tick();
      req_valid = (c < 8);
      req_addr  = c;
      #1;
      if (c < 8) chk("st_ready", 32'(req_ready), 1);
      if (c >= 2 && c < 10) begin
        chk("st_valid", 32'(resp_valid), 1);
        chk("st_addr", resp_addr, c - 2);
        chk("st_instr", resp_instr, 32'h100 + c - 2);
      end else begin
        chk("st_idle", 32'(resp_valid), 0);
      end
    end

    // Backpressure: exactly FIFO_DEPTH accepts, head holds addr 0
    resp_ready = 0; next_addr = 0; acc = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      req_valid = 1; req_addr = next_addr;
      #1;
      if (req_ready) begin acc++; next_addr++; end
    end
    chk("bp_accepts", acc, 4);
    chk("bp_ready", 32'(req_ready), 0);
    chk("bp_head_valid", 32'(resp_valid), 1);
    chk("bp_head_addr", resp_addr, 0);
    rx = 0;
    for (int c = 0; c < 60 && rx < 12; c++) begin
      tick();
      resp_ready = 1;
      req_valid = (next_addr < 12); req_addr = next_addr;
      #1;
      if (req_valid && req_ready) next_addr++;
      if (resp_valid) begin
        chk("bp_addr", resp_addr, rx);
        chk("bp_instr", resp_instr, 32'h100 + rx);
        rx++;
      end
    end
    chk("bp_count", rx, 12);
    tick(); req_valid = 0;
    tick(); tick(); tick();

    // Flush discards 0,1,2; only 20 is returned
    resp_ready = 0;
    for (int a = 0; a < 3; a++) begin
      tick(); req_valid = 1; req_addr = a;
      #1; chk("fl_acc_ready", 32'(req_ready), 1);
    end
    tick(); req_addr = 20; flush = 1;
    #1; chk("fl_ready_forced", 32'(req_ready), 0);
    tick(); flush = 0; req_valid = 1; req_addr = 20; resp_ready = 1;
    #1;
    chk("fl_empty", 32'(resp_valid), 0);
    chk("fl_ready_after", 32'(req_ready), 1);
    tick(); req_valid = 0;
    #1; chk("fl_lat1", 32'(resp_valid), 0);
    tick();
    chk("fl_valid", 32'(resp_valid), 1);
    chk("fl_addr", resp_addr, 20);
    chk("fl_instr", resp_instr, 32'h114);
    tick(); chk("fl_done", 32'(resp_valid), 0);
    tick(); chk("fl_done2", 32'(resp_valid), 0);

    // Out-of-range address then a legal one
    tick(); req_valid = 1; req_addr = 256;
    tick(); req_addr = 3;
    tick(); req_valid = 0;
    #1;
    chk("oor_addr", resp_addr, 256);
    chk("oor_instr", resp_instr, 32'h0);
    chk("oor_err", 32'(resp_err), 1);
    tick();
    chk("oor_next_addr", resp_addr, 3);
    chk("oor_next_instr", resp_instr, 32'h103);
    chk("oor_next_err", 32'(resp_err), 0);

    // Read-before-write, and an out-of-range write must not alias
    tick(); req_valid = 1; req_addr = 5; wr_en = 1; wr_addr = 5; wr_data = 32'hABCD0005;
    tick(); req_valid = 0; wr_addr = 261; wr_data = 32'hDEADBEEF;
    tick(); wr_en = 0; req_valid = 1; req_addr = 5;
    #1; chk("rbw_old", resp_instr, 32'h105);
    tick(); req_valid = 0;
    tick();
    chk("rbw_new_addr", resp_addr, 5);
    chk("rbw_new", resp_instr, 32'hABCD0005);
    tick(); tick();

    // Reset with pipeline and FIFO full
    resp_ready = 0;
    for (int a = 8; a < 12; a++) begin
      tick(); req_valid = 1; req_addr = a;
    end
    tick(); #1; chk("rm_full", 32'(req_ready), 0);
    tick(); req_valid = 0; reset = 1;
    tick(); reset = 0;
    #1;
    chk("rm_valid", 32'(resp_valid), 0);
    chk("rm_ready", 32'(req_ready), 1);
    chk("rm_addr", resp_addr, 0);
    chk("rm_instr", resp_instr, 0);
    req_valid = 1; req_addr = 7; resp_ready = 1;
    tick(); req_valid = 0;
    tick();
    chk("rm_fetch_addr", resp_addr, 7);
    chk("rm_fetch_instr", resp_instr, 32'h107);
    tick(); tick();

`ifdef FETCH_STATS_EN
    // 10 accepts, 3 stalls, 2 flush cycles
    tick(); reset = 1;
    tick(); reset = 0; resp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick(); req_valid = 1; req_addr = i;
    end
    tick(); req_valid = 0;
    tick(); tick(); tick(); tick();
    resp_ready = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); req_valid = 1; req_addr = i;
    end
    tick(); tick(); tick();
    tick(); req_valid = 0; flush = 1;
    tick();
    tick(); flush = 0;
    #1;
    chk("stat_fetches", stat_fetches, 10);
    chk("stat_flushes", stat_flushes, 2);
    chk("stat_stalls", stat_stalls, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
